// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Initiator side of the processor DIN/Run/Done handshake. A host loads a
//   small program memory, then pulses Start with a length; the sequencer
//   presents words 0..Len-1 on DIN, one at a time. Each word gets a one-cycle
//   Run strobe, and the next word follows the cycle after Done, so there are
//   no bubbles.
//
//   Parameters:
//     AW       program address width, memory depth 2**AW x 16 bits
//     TIMEOUT  cycles allowed in WAIT without Done (WATCHDOG_EN builds only)
//
//   Optional feature macro: WATCHDOG_EN (adds a Done watchdog and sticky Error)
//
//   Ports:
//     Clock, Resetn   rising-edge clock, synchronous active-low reset
//     prog_we/addr/data  program write port; writes accepted in IDLE only
//     Start, Len      launch a run of Len instructions (sampled in IDLE)
//     DIN, Run        instruction word and one-cycle valid strobe
//     Done            instruction complete, combinational from the core
//     Busy            high in ISSUE and WAIT
//     Finished        one-cycle pulse on normal completion
//     Icount          instructions completed in the current/last run
//     Error           sticky watchdog error (constant 0 without WATCHDOG_EN)
module instr_sequencer #(
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          Start,
  input  logic [AW:0]   Len,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          Finished,
  output logic [AW:0]   Icount,
  output logic          Error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [15:0]   mem [0:(2**AW)-1];
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [AW:0]   len_q;
  logic [AW:0]   icount_next;
  logic [15:0]   word0;

  assign pc_next     = pc + 1'b1;
  assign icount_next = Icount + 1'b1;
  // A write to address 0 in the same cycle as Start must be seen by the
  // first issue, so forward it around the memory.
  assign word0 = (prog_we && (prog_addr == '0)) ? prog_data : mem[0];

  // Program memory: not reset, writable only while idle.
  always_ff @(posedge Clock) begin
    if (prog_we && (state == IDLE)) mem[prog_addr] <= prog_data;
  end

`ifdef WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd;
`else
  assign Error = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state    <= IDLE;
      DIN      <= '0;
      Run      <= 1'b0;
      Busy     <= 1'b0;
      Finished <= 1'b0;
      Icount   <= '0;
      pc       <= '0;
      len_q    <= '0;
`ifdef WATCHDOG_EN
      Error    <= 1'b0;
      wd       <= '0;
`endif
    end else begin
      Finished <= 1'b0;
      case (state)
        IDLE: begin
          Run  <= 1'b0;
          Busy <= 1'b0;
          if (Start) begin
            Icount <= '0;
`ifdef WATCHDOG_EN
            Error  <= 1'b0;
`endif
            if (Len != '0) begin
              len_q <= Len;
              pc    <= '0;
              DIN   <= word0;
              Run   <= 1'b1;
              Busy  <= 1'b1;
              state <= ISSUE;
            end else begin
              Finished <= 1'b1;
            end
          end
        end

        ISSUE: begin
          // Done here belongs to the previous instruction's core cycle; ignore.
          Run   <= 1'b0;
          state <= WAIT;
`ifdef WATCHDOG_EN
          wd    <= '0;
`endif
        end

        WAIT: begin
          if (Done) begin
            Icount <= icount_next;
            pc     <= pc_next;
            if (icount_next == len_q) begin
              Busy     <= 1'b0;
              Finished <= 1'b1;
              state    <= IDLE;
            end else begin
              DIN   <= mem[pc_next];
              Run   <= 1'b1;
              state <= ISSUE;
            end
          end
`ifdef WATCHDOG_EN
          else if (wd == WDW'(TIMEOUT - 1)) begin
            Error <= 1'b1;
            Run   <= 1'b0;
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end

        default: begin
          Run   <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer. Expected Run/DIN and Finished/Icount events
// are queued when a run is launched; a monitor pops them as the DUT shows
// Run or Finished. A behavioural core answers Run with Done after 1 WAIT
// cycle for mv/mvt and 3 WAIT cycles for add/sub, and tracks its registers.
module tb_instr_sequencer;

  localparam int unsigned AW = 4;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic          Start = 1'b0;
  logic [AW:0]   Len = '0;
  logic [15:0]   DIN;
  logic          Run;
  logic          Done = 1'b0;
  logic          Busy;
  logic          Finished;
  logic [AW:0]   Icount;
  logic          Error;

  instr_sequencer #(.AW(AW), .TIMEOUT(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Start(Start), .Len(Len), .DIN(DIN), .Run(Run),
    .Done(Done), .Busy(Busy), .Finished(Finished), .Icount(Icount), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  typedef struct {bit fin; logic [15:0] val; int c;} exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;
  int last_fin = -1;
  logic [15:0] shadow [16];
  logic [15:0] r [8];
  bit hang = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int steps(input logic [15:0] w);
    return (w[15:13] == 3'b010 || w[15:13] == 3'b011) ? 3 : 1;
  endfunction

  // Monitor
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (Run) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL run_unexpected cyc=%0d DIN=%h", cyc, DIN);
      end else begin
        e = q.pop_front();
        if (e.fin || e.c != cyc || e.val !== DIN) begin
          miscompares++;
          $display("FAIL run_issue got cyc=%0d DIN=%h exp fin=%0d cyc=%0d DIN=%h",
                   cyc, DIN, e.fin, e.c, e.val);
        end
      end
    end
    if (Finished) begin
      vectors++;
      last_fin = cyc;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL finish_unexpected cyc=%0d Icount=%0d", cyc, Icount);
      end else begin
        e = q.pop_front();
        if (!e.fin || e.c != cyc || e.val[AW:0] !== Icount) begin
          miscompares++;
          $display("FAIL finish got cyc=%0d Icount=%0d exp fin=%0d cyc=%0d Icount=%0d",
                   cyc, Icount, e.fin, e.c, e.val);
        end
      end
    end
  end

  // Behavioural core: Done handshake plus mv/add register effects.
  int wcnt = 0;
  logic [15:0] cur_ir = '0;
  always @(posedge Clock) begin
    #1;
    if (!Resetn) begin
      wcnt = 0;
      Done = 1'b0;
    end else if (Run) begin
      cur_ir = DIN;
      wcnt = steps(DIN);
      Done = 1'b0;
    end else if (wcnt > 0 && !hang) begin
      wcnt--;
      Done = (wcnt == 0);
      if (wcnt == 0) begin
        case (cur_ir[15:13])
          3'b000: r[cur_ir[11:9]] = {7'd0, cur_ir[8:0]};
          3'b010: r[cur_ir[11:9]] = r[cur_ir[11:9]] + {7'd0, cur_ir[8:0]};
          default: ;
        endcase
      end
    end else begin
      Done = 1'b0;
    end
  end

  task automatic load(input int a, input logic [15:0] d);
    @(negedge Clock);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    shadow[a] = d;
    @(negedge Clock);
    prog_we = 1'b0;
  endtask

  // Queue expected events for a run of len words starting at edge s.
  // limit >= 0: only the first limit issues are expected and no Finished.
  task automatic push_prog(input int s, input int len, input int limit);
    int c;
    logic [15:0] w;
    c = s;
    for (int k = 0; k < len; k++) begin
      if (limit >= 0 && k >= limit) return;
      w = shadow[k % 16];
      q.push_back('{1'b0, w, c});
      c += 1 + steps(w);
    end
    if (limit < 0) q.push_back('{1'b1, 16'(len), c});
  endtask

  task automatic go(input int len, input int limit, input bit fwd, input logic [15:0] fwd_d,
                    output int s);
    @(negedge Clock);
    s = cyc + 1;
    if (fwd) begin
      shadow[0] = fwd_d;
      prog_we = 1'b1; prog_addr = '0; prog_data = fwd_d;
    end
    push_prog(s, len, limit);
    Start = 1'b1; Len = (AW+1)'(len);
    @(negedge Clock);
    Start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (!Busy && q.size() == 0) return;
      @(negedge Clock);
    end
    vectors++;
    miscompares++;
    $display("FAIL %s_timeout got busy=%0d pending=%0d exp idle", name, Busy, q.size());
  endtask

  initial begin
    int s;
    int errc;
    for (int i = 0; i < 8; i++) r[i] = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 'x;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    chk("rst_run", {31'd0, Run}, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_fin", {31'd0, Finished}, 0);
    chk("rst_icount", {27'd0, Icount}, 0);
    chk("rst_din", {16'd0, DIN}, 0);
    chk("rst_error", {31'd0, Error}, 0);

    // mv r1,#5 ; add r1,#3 with mem[0] written in the Start cycle (forwarded)
    load(0, 16'h0000);
    load(1, 16'h5203);
    go(2, -1, 1'b1, 16'h1205, s);
    chk("t1_busy", {31'd0, Busy}, 1);
    wait_idle("t1");
    chk("t1_fin_cycle", last_fin, s + 6);
    chk("t1_icount", {27'd0, Icount}, 2);
    chk("t1_r1", {16'd0, r[1]}, 16'h0008);

    // Len = 0: Finished next cycle, never busy, no Run
    go(0, -1, 1'b0, '0, s);
    chk("t2_busy", {31'd0, Busy}, 0);
    chk("t2_fin_cycle", last_fin, s);
    chk("t2_icount", {27'd0, Icount}, 0);

    // Full memory, pc wraps
    for (int i = 0; i < 16; i++) load(i, 16'h1000 | 16'(i));
    go(16, -1, 1'b0, '0, s);
    wait_idle("t3");
    chk("t3_fin_cycle", last_fin, s + 32);
    chk("t3_icount", {27'd0, Icount}, 16);
    chk("t3_r0", {16'd0, r[0]}, 15);

    // Write and Start while busy are ignored
    for (int i = 0; i < 4; i++) load(i, 16'h1401 + 16'(i));
    go(4, -1, 1'b0, '0, s);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'hFFFF;
    Start = 1'b1; Len = 5'd1;
    repeat (2) @(negedge Clock);
    prog_we = 1'b0; Start = 1'b0;
    wait_idle("t4");
    chk("t4_icount", {27'd0, Icount}, 4);
    go(2, -1, 1'b0, '0, s);
    wait_idle("t4b");
    chk("t4b_r2", {16'd0, r[2]}, 16'h0002);

    // Reset during WAIT of the second instruction
    load(1, 16'h5403);
    go(4, 2, 1'b0, '0, s);
    while (cyc < s + 3) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    chk("t5_run", {31'd0, Run}, 0);
    chk("t5_busy", {31'd0, Busy}, 0);
    chk("t5_icount", {27'd0, Icount}, 0);
    repeat (8) @(negedge Clock);
    chk("t5_pending", q.size(), 0);
    go(2, -1, 1'b0, '0, s);
    wait_idle("t5b");
    chk("t5b_icount", {27'd0, Icount}, 2);

`ifdef WATCHDOG_EN
    hang = 1'b1;
    go(1, 1, 1'b0, '0, s);
    errc = -1;
    for (int i = 0; i < 40 && errc < 0; i++) begin
      @(posedge Clock); #2;
      if (Error) errc = cyc;
    end
    chk("wd_error_cycle", errc, s + 17);
    chk("wd_busy", {31'd0, Busy}, 0);
    chk("wd_icount", {27'd0, Icount}, 0);
    hang = 1'b0;
    repeat (4) @(negedge Clock);
    chk("wd_sticky", {31'd0, Error}, 1);
    go(1, -1, 1'b0, '0, s);
    chk("wd_cleared", {31'd0, Error}, 0);
    wait_idle("wd_rerun");
`else
    errc = 0;
    chk("no_wd_error", {31'd0, Error}, errc);
`endif

    repeat (4) @(negedge Clock);
    chk("final_pending", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
